// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V fetch front end.
package riscv_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load, stall and flush controls, plus the rs1/rs2
// index slices the hazard unit compares against.
module ifid_reg
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INDEX = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load_in,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] instr_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instr_out,
  output logic [INDEX-1:0] rs1_out,
  output logic [INDEX-1:0] rs2_out
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;

  // Bubbles keep the previous pc so only valid/instr change on flush.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_in) begin
      valid_d = 1'b0;
      instr_d = WIDTH'(NOP_INSTR);
    end else if (load_in) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end else if (!stall_in) begin
      valid_d = 1'b0;
      instr_d = WIDTH'(NOP_INSTR);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= WIDTH'(NOP_INSTR);
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_out = valid_q;
  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign rs1_out   = instr_q[RS1_LSB +: INDEX];
  assign rs2_out   = instr_q[RS2_LSB +: INDEX];
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, one-entry
// response buffer and IF/ID register. FETCH_PERF_CNT_EN adds a bubble counter.
//
// state | meaning
// FETCH | request pc, wait for grant
// WAIT  | granted, wait for response
// HOLD  | response buffered while ID is stalled
// DRAIN | discard the response of a killed request
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               INDEX    = 5,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             stall_in,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_gnt_in,
  input  logic             imem_rvalid_in,
  input  logic [WIDTH-1:0] imem_rdata_in,
  output logic             ifid_valid_out,
  output logic [WIDTH-1:0] ifid_pc_out,
  output logic [WIDTH-1:0] ifid_instr_out,
  output logic [INDEX-1:0] ifid_rs1_out,
  output logic [INDEX-1:0] ifid_rs2_out
`ifdef FETCH_PERF_CNT_EN
 ,output logic [31:0]      perf_bubble_cnt_out
`endif
);
  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic             load;
  logic [WIDTH-1:0] load_pc, load_instr;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    load        = 1'b0;
    load_pc     = pend_pc_q;
    load_instr  = imem_rdata_in;
    case (state_q)
      FETCH: if (imem_gnt_in) begin
        pend_pc_d = pc_q;
        pc_d      = pc_q + WIDTH'(PC_STEP);
        state_d   = WAIT;
      end
      WAIT: if (imem_rvalid_in) begin
        if (!stall_in) begin
          load    = 1'b1;
          state_d = FETCH;
        end else begin
          buf_pc_d    = pend_pc_q;
          buf_instr_d = imem_rdata_in;
          state_d     = HOLD;
        end
      end
      HOLD: if (!stall_in) begin
        load       = 1'b1;
        load_pc    = buf_pc_q;
        load_instr = buf_instr_q;
        state_d    = FETCH;
      end
      DRAIN: if (imem_rvalid_in) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    // Redirect wins over everything; a granted or in-flight request must drain.
    if (redirect_in) begin
      load = 1'b0;
      pc_d = redirect_pc_in & ~WIDTH'(3);
      case (state_q)
        FETCH:   state_d = imem_gnt_in ? DRAIN : FETCH;
        WAIT:    state_d = imem_rvalid_in ? FETCH : DRAIN;
        HOLD:    state_d = FETCH;
        DRAIN:   state_d = imem_rvalid_in ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= WIDTH'(NOP_INSTR);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign imem_req_out  = (state_q == FETCH) && !rst_in;
  assign imem_addr_out = pc_q;

  ifid_reg #(.WIDTH(WIDTH), .INDEX(INDEX)) u_ifid (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load_in   (load),
    .stall_in  (stall_in),
    .flush_in  (redirect_in),
    .pc_in     (load_pc),
    .instr_in  (load_instr),
    .valid_out (ifid_valid_out),
    .pc_out    (ifid_pc_out),
    .instr_out (ifid_instr_out),
    .rs1_out   (ifid_rs1_out),
    .rs2_out   (ifid_rs2_out)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (!ifid_valid_out && perf_cnt_q != 32'hFFFF_FFFF) perf_cnt_d = perf_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) perf_cnt_q <= '0;
    else        perf_cnt_q <= perf_cnt_d;
  end

  assign perf_bubble_cnt_out = perf_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory handshake driven step by step,
// every expectation hand-computed.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in = 1'b0;
  logic        imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic        ifid_valid_out;
  logic [31:0] ifid_pc_out;
  logic [31:0] ifid_instr_out;
  logic [4:0]  ifid_rs1_out;
  logic [4:0]  ifid_rs2_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  fetch_stage dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .stall_in       (stall_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .imem_req_out   (imem_req_out),
    .imem_addr_out  (imem_addr_out),
    .imem_gnt_in    (imem_gnt_in),
    .imem_rvalid_in (imem_rvalid_in),
    .imem_rdata_in  (imem_rdata_in),
    .ifid_valid_out (ifid_valid_out),
    .ifid_pc_out    (ifid_pc_out),
    .ifid_instr_out (ifid_instr_out),
    .ifid_rs1_out   (ifid_rs1_out),
    .ifid_rs2_out   (ifid_rs2_out)
`ifdef FETCH_PERF_CNT_EN
   ,.perf_bubble_cnt_out (perf_bubble_cnt_out)
`endif
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem(input logic gnt, input logic rv, input logic [31:0] rd);
    imem_gnt_in    = gnt;
    imem_rvalid_in = rv;
    imem_rdata_in  = rd;
  endtask

  initial begin
    // reset
    tick(); tick();
    check("rst_valid", 32'(ifid_valid_out), 32'd0);
    check("rst_pc", ifid_pc_out, 32'h0);
    check("rst_instr", ifid_instr_out, NOP);
    check("rst_rs1", 32'(ifid_rs1_out), 32'd0);
    check("rst_rs2", 32'(ifid_rs2_out), 32'd0);
    check("rst_req", 32'(imem_req_out), 32'd0);
    rst_in = 1'b0; #1;
    check("first_req", 32'(imem_req_out), 32'd1);
    check("first_addr", imem_addr_out, 32'h0);

    // zero-wait memory: 0x0, 0x4, 0x8
    mem(1, 0, 0); tick();
    check("wait_req", 32'(imem_req_out), 32'd0);
    check("wait_valid", 32'(ifid_valid_out), 32'd0);
    mem(0, 1, 32'h0010_0093); tick();
    check("i0_valid", 32'(ifid_valid_out), 32'd1);
    check("i0_pc", ifid_pc_out, 32'h0);
    check("i0_instr", ifid_instr_out, 32'h0010_0093);
    check("i0_next_addr", imem_addr_out, 32'h4);
    mem(1, 0, 0); tick();
    check("bub_valid", 32'(ifid_valid_out), 32'd0);
    check("bub_instr", ifid_instr_out, NOP);
    check("bub_pc_hold", ifid_pc_out, 32'h0);
    mem(0, 1, 32'h0041_8233); tick();
    check("i1_pc", ifid_pc_out, 32'h4);
    check("i1_rs1", 32'(ifid_rs1_out), 32'd3);
    check("i1_rs2", 32'(ifid_rs2_out), 32'd4);
    check("i1_next_addr", imem_addr_out, 32'h8);
    mem(1, 0, 0); tick();
    mem(0, 1, 32'h0020_8033); tick();
    check("i2_pc", ifid_pc_out, 32'h8);
    check("i2_rs1", 32'(ifid_rs1_out), 32'd1);
    check("i2_rs2", 32'(ifid_rs2_out), 32'd2);

    // stall: response for 0xC buffered, IF/ID frozen
    stall_in = 1'b1;
    mem(1, 0, 0); tick();
    check("stall_gnt_pc", ifid_pc_out, 32'h8);
    mem(0, 1, 32'h00C5_8533); tick();
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 32'(ifid_valid_out), 32'd1);
      check("hold_pc", ifid_pc_out, 32'h8);
      check("hold_instr", ifid_instr_out, 32'h0020_8033);
      check("hold_req", 32'(imem_req_out), 32'd0);
      mem(0, 0, 0);
      if (i < 2) tick();
    end
    stall_in = 1'b0; tick();
    check("rel_valid", 32'(ifid_valid_out), 32'd1);
    check("rel_pc", ifid_pc_out, 32'hC);
    check("rel_instr", ifid_instr_out, 32'h00C5_8533);
    check("rel_rs1", 32'(ifid_rs1_out), 32'd11);
    check("rel_rs2", 32'(ifid_rs2_out), 32'd12);
    check("rel_addr", imem_addr_out, 32'h10);

    // redirect in WAIT without rvalid, then late response dropped
    stall_in = 1'b1;
    mem(1, 0, 0); tick();
    check("pre_redir_valid", 32'(ifid_valid_out), 32'd1);
    stall_in = 1'b0; redirect_in = 1'b1; redirect_pc_in = 32'h103;
    mem(0, 0, 0); tick();
    check("redir_valid", 32'(ifid_valid_out), 32'd0);
    check("drain_req", 32'(imem_req_out), 32'd0);
    redirect_in = 1'b0;
    mem(0, 1, 32'hDEAD_BEEF); tick();
    check("late_drop_valid", 32'(ifid_valid_out), 32'd0);
    check("late_drop_instr", ifid_instr_out, NOP);
    check("redir_req", 32'(imem_req_out), 32'd1);
    check("redir_addr", imem_addr_out, 32'h100);

    // redirect + stall with valid IF/ID: flush wins
    mem(1, 0, 0); tick();
    mem(0, 1, 32'h0010_0093); tick();
    check("t100_pc", ifid_pc_out, 32'h100);
    stall_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = 32'hFFFF_FFFC;
    mem(0, 0, 0); tick();
    check("flush_valid", 32'(ifid_valid_out), 32'd0);
    check("flush_instr", ifid_instr_out, NOP);
    check("flush_rs1", 32'(ifid_rs1_out), 32'd0);
    check("flush_addr", imem_addr_out, 32'hFFFF_FFFC);
    check("flush_req", 32'(imem_req_out), 32'd1);

    // PC wrap
    stall_in = 1'b0; redirect_in = 1'b0;
    mem(1, 0, 0); tick();
    mem(0, 1, 32'h0041_8233); tick();
    check("wrap_pc", ifid_pc_out, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr_out, 32'h0);

    // redirect coincident with grant must drain the granted request
    redirect_in = 1'b1; redirect_pc_in = 32'h200;
    mem(1, 0, 0); tick();
    check("gnt_redir_req", 32'(imem_req_out), 32'd0);
    check("gnt_redir_valid", 32'(ifid_valid_out), 32'd0);
    redirect_in = 1'b0;
    mem(0, 0, 0); tick();
    check("drain_wait_req", 32'(imem_req_out), 32'd0);
    mem(0, 1, 32'h1234_5678); tick();
    check("drain_done_req", 32'(imem_req_out), 32'd1);
    check("drain_done_addr", imem_addr_out, 32'h200);
    check("drain_done_valid", 32'(ifid_valid_out), 32'd0);

    // reset while in WAIT with valid IF/ID
    mem(1, 0, 0); tick();
    mem(0, 1, 32'h00C5_8533); tick();
    check("t200_pc", ifid_pc_out, 32'h200);
    stall_in = 1'b1;
    mem(1, 0, 0); tick();
    check("pre_rst_valid", 32'(ifid_valid_out), 32'd1);
    stall_in = 1'b0; rst_in = 1'b1;
    mem(0, 0, 0); #1;
    check("mid_rst_req", 32'(imem_req_out), 32'd0);
    tick();
    check("mid_rst_valid", 32'(ifid_valid_out), 32'd0);
    check("mid_rst_instr", ifid_instr_out, NOP);
    check("mid_rst_addr", imem_addr_out, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_rst", perf_bubble_cnt_out, 32'd0);
`endif
    rst_in = 1'b0; #1;
    check("post_rst_req", 32'(imem_req_out), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("idle_valid", 32'(ifid_valid_out), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_5", perf_bubble_cnt_out, 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline: PC register, instruction-memory req/gnt/rvalid handshake, one-entry response buffer, IF/ID pipeline register.
- Consumes stall_in from the hazard detection unit and redirect from EX branch resolution.
- Produces the IF/ID fields, including the rs1/rs2 indices the hazard unit compares against.

Parameters:
- WIDTH, 32, data/address width.
- INDEX, 5, register-index width.
- RESET_PC, 32'h0000_0000, PC after reset.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- stall_in  input  1  hazard stall; IF/ID holds.
- redirect_in  input  1  branch/jump taken; flush and refetch.
- redirect_pc_in  input  WIDTH  redirect target.
- imem_req_out  output  1  fetch request.
- imem_addr_out  output  WIDTH  fetch address, word aligned.
- imem_gnt_in  input  1  request accepted this cycle.
- imem_rvalid_in  input  1  response data valid.
- imem_rdata_in  input  WIDTH  fetched instruction.
- ifid_valid_out  output  1  IF/ID holds a real instruction.
- ifid_pc_out  output  WIDTH  PC of IF/ID instruction.
- ifid_instr_out  output  WIDTH  IF/ID instruction.
- ifid_rs1_out  output  INDEX  ifid_instr_out[19:15].
- ifid_rs2_out  output  INDEX  ifid_instr_out[24:20].

Behaviour:
- Reset (rst_in=1 at edge):
  - pc=RESET_PC, state=FETCH.
  - ifid_valid=0, ifid_pc=0, ifid_instr=NOP (32'h0000_0013).
  - Buffer empty, imem_req_out=0 during reset.
  - Reset mid-transaction abandons any outstanding request; imem shares rst_in.
- Single outstanding request at most. States:
  - FETCH: req=1, addr=pc. gnt → pending_pc<=pc, pc<=pc+4 (mod 2^WIDTH), go WAIT. No gnt → stay, addr held.
  - WAIT: req=0.
    - rvalid and stall_in=0 → IF/ID loads {1, pending_pc, rdata}, go FETCH.
    - rvalid and stall_in=1 → rdata+pending_pc into buffer, go HOLD.
  - HOLD: req=0. stall_in=0 → IF/ID loads buffer, buffer empties, go FETCH.
  - DRAIN: req=0, waits for the response to a killed request. rvalid → data discarded, go FETCH.
- IF/ID update, redirect excluded:
  - stall_in=1 → all IF/ID fields hold, including a bubble.
  - stall_in=0 with no data this cycle → bubble: valid=0, instr=NOP, pc holds.
- Latency: gnt at cycle N and rvalid at N+1 → ifid_valid_out=1 at N+2. Back-to-back zero-wait memory sustains one instruction per 2 cycles.
- Redirect has highest priority, overriding stall_in:
  - pc<=redirect_pc_in with bits [1:0] forced 0.
  - IF/ID flushed to bubble; buffer emptied.
  - Next state by current state:
    - FETCH without gnt → FETCH, new addr next cycle.
    - FETCH with gnt → DRAIN.
    - WAIT without rvalid → DRAIN.
    - WAIT with rvalid → FETCH, data discarded.
    - HOLD → FETCH.
    - DRAIN without rvalid → DRAIN.
    - DRAIN with rvalid → FETCH.
- imem_addr_out may change while req=1 without gnt only on a redirect.
- ifid_rs1_out/ifid_rs2_out are purely combinational slices of ifid_instr_out. A bubble yields 0.
- No instruction is ever duplicated or lost; stale-path responses never reach IF/ID.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output perf_bubble_cnt_out [31:0].
  - Increments each cycle ifid_valid_out=0 and rst_in=0.
  - Saturates at 32'hFFFF_FFFF; reset to 0.
- Undefined: port and counter absent; otherwise identical behaviour.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR constant.
  - RS1_LSB=15, RS2_LSB=20.
  - fetch_state_t enum {FETCH, WAIT, HOLD, DRAIN}.
  - PC_STEP=4.
- Sub-module ifid_reg: IF/ID register with load/stall/flush controls and rs field slicing. The fetch FSM, PC and buffer stay in fetch_stage.

Test Plan:
- Reset, RESET_PC=0, zero-wait memory (gnt immediate, rvalid next cycle) → addrs 0x0,0x4,0x8 issued in order; ifid_pc_out 0x0 then 0x4; first ifid_valid_out=1 two cycles after first gnt.
- stall_in=1 for 3 cycles while IF/ID holds 0x00208033 at pc 0x8, rvalid arrives → IF/ID unchanged for 3 cycles; rs1=1, rs2=2; on release, buffered pc 0xC appears next cycle; no request issued while in HOLD.
- redirect_in=1, redirect_pc_in=0x103, in WAIT without rvalid → ifid_valid_out=0 next cycle; late rvalid discarded; next request addr 0x100.
- redirect_in and stall_in both 1 with valid IF/ID → flush wins: ifid_valid_out=0, ifid_instr_out=NOP.
- pc=0xFFFF_FFFC granted → next addr 0x0000_0000.
- rst_in asserted in WAIT → state FETCH, addr RESET_PC; ifid_valid_out=0; with FETCH_PERF_CNT_EN, 5 bubble cycles give perf_bubble_cnt_out=5.
